// File: rtl/fifo.sv
// fifo: single-clock synchronous FIFO, 64 x 8 by default, with registered read data, flags and occupancy count
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset; deassert synchronously to clk
//   buf_in       write data, stored when a write is accepted
//   buf_out      registered read data, updated one edge after a read is accepted
//   wr_en        write request, accepted when not full
//   rd_en        read request, accepted when not empty
//   buf_empty    high when fifo_counter == 0
//   buf_full     high when fifo_counter == DEPTH
//   fifo_counter number of stored entries, 0..DEPTH
//   overflow     sticky: write attempted while full with no read accepted
//                (only when FIFO_ERR_FLAGS_EN is defined)
//   underflow    sticky: read attempted while empty
//                (only when FIFO_ERR_FLAGS_EN is defined)
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    output logic [DATA_WIDTH-1:0] buf_out,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic [ADDR_WIDTH:0]   fifo_counter
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign buf_empty = fifo_counter == '0;
    assign buf_full  = fifo_counter == (ADDR_WIDTH+1)'(DEPTH);
    assign wr_ok     = wr_en && !buf_full;
    assign rd_ok     = rd_en && !buf_empty;

    // Storage is not reset; gating with rst keeps an edge under reset from writing.
    always_ff @(posedge clk)
        if (rst && wr_ok) mem[wr_ptr] <= buf_in;

    // Pointers are exactly ADDR_WIDTH wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
            buf_out      <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                buf_out <= mem[rd_ptr];
            end
            fifo_counter <= (wr_ok && !rd_ok) ? fifo_counter + 1'b1 :
                            (rd_ok && !wr_ok) ? fifo_counter - 1'b1 : fifo_counter;
        end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && buf_full && !rd_ok) overflow <= 1'b1;
            if (rd_en && buf_empty) underflow <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed stimulus with a queue-based reference model and per-cycle compare for fifo
module tb_fifo;
    logic       clk = 0;
    logic       rst = 0;
    logic       wr_en = 0;
    logic       rd_en = 0;
    logic [7:0] buf_in = 0;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       buf_full;
    logic [6:0] fifo_counter;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int passed = 0;
    int total = 0;
    bit live = 0;

    logic [7:0] q[$];
    logic [7:0] m_out = 0;
    bit         m_ovf = 0;
    bit         m_unf = 0;

    always #5 clk = ~clk;

    fifo dut (
        .clk(clk),
        .rst(rst),
        .buf_in(buf_in),
        .buf_out(buf_out),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .buf_empty(buf_empty),
        .buf_full(buf_full),
        .fifo_counter(fifo_counter)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk)
        if (live) begin
            chk("count", 32'(fifo_counter), 32'(q.size()));
            chk("empty", 32'(buf_empty), 32'(q.size() == 0));
            chk("full", 32'(buf_full), 32'(q.size() == 64));
            chk("buf_out", 32'(buf_out), 32'(m_out));
`ifdef FIFO_ERR_FLAGS_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
`endif
        end

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bit wa;
        bit ra;
        wr_en = w;
        rd_en = r;
        buf_in = d;
        @(posedge clk);
        if (rst) begin
            wa = w && q.size() < 64;
            ra = r && q.size() > 0;
            if (w && q.size() == 64 && !ra) m_ovf = 1;
            if (r && q.size() == 0) m_unf = 1;
            if (ra) m_out = q.pop_front();
            if (wa) q.push_back(d);
        end
        #1;
        wr_en = 0;
        rd_en = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        q.delete();
        m_out = 0;
        m_ovf = 0;
        m_unf = 0;
        chk("rst_count", 32'(fifo_counter), 0);
        chk("rst_empty", 32'(buf_empty), 1);
        chk("rst_full", 32'(buf_full), 0);
        chk("rst_buf_out", 32'(buf_out), 0);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        live = 1;
        step(1, 0, 18); chk("basic_cnt1", 32'(fifo_counter), 1);
        step(1, 0, 9);  chk("basic_cnt2", 32'(fifo_counter), 2);
        step(1, 0, 20); chk("basic_cnt3", 32'(fifo_counter), 3);
        step(0, 1, 0);  chk("basic_out18", 32'(buf_out), 18); chk("basic_cnt2r", 32'(fifo_counter), 2);
        step(0, 1, 0);  chk("basic_out9", 32'(buf_out), 9);   chk("basic_cnt1r", 32'(fifo_counter), 1);
        step(0, 1, 0);  chk("basic_out20", 32'(buf_out), 20); chk("basic_cnt0r", 32'(fifo_counter), 0);
        chk("basic_empty", 32'(buf_empty), 1);
        step(1, 0, 1); step(1, 0, 2); step(1, 0, 3);
        step(1, 1, 40); chk("conc_out1", 32'(buf_out), 1); chk("conc_cnt_a", 32'(fifo_counter), 3);
        step(1, 1, 64); chk("conc_out2", 32'(buf_out), 2); chk("conc_cnt_b", 32'(fifo_counter), 3);
        step(0, 1, 0); chk("conc_out3", 32'(buf_out), 3);
        step(0, 1, 0); chk("conc_out40", 32'(buf_out), 40);
        step(0, 1, 0); chk("conc_out64", 32'(buf_out), 64);
        step(1, 0, 7); step(1, 0, 8);
        do_reset();
        for (int i = 0; i < 64; i++) step(1, 0, 8'(i));
        chk("full_flag", 32'(buf_full), 1); chk("full_cnt", 32'(fifo_counter), 64);
        step(1, 0, 99); chk("full_drop_cnt", 32'(fifo_counter), 64);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow_set", 32'(overflow), 1);
`endif
        for (int i = 0; i < 64; i++) begin
            step(0, 1, 0);
            chk("full_drain", 32'(buf_out), i);
        end
        chk("drain_empty", 32'(buf_empty), 1);
        step(1, 1, 5); chk("emp_rw_cnt", 32'(fifo_counter), 1); chk("emp_rw_hold", 32'(buf_out), 63);
        step(0, 1, 0); chk("emp_rw_read5", 32'(buf_out), 5);
        step(0, 1, 0); chk("emp_rd_hold", 32'(buf_out), 5);
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow_set", 32'(underflow), 1);
`endif
        for (int i = 0; i < 40; i++) step(1, 0, 8'(i + 1));
        for (int i = 0; i < 40; i++) step(0, 1, 0);
        for (int i = 0; i < 40; i++) step(1, 0, 8'(100 + i));
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0);
            chk("wrap_order", 32'(buf_out), 100 + i);
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow_sticky", 32'(underflow), 1);
`endif
        for (int i = 0; i < 64; i++) step(1, 0, 8'(i * 3));
        step(1, 1, 77); chk("full_rw_cnt", 32'(fifo_counter), 63); chk("full_rw_out", 32'(buf_out), 0);
        for (int i = 0; i < 63; i++) step(0, 1, 0);
        chk("full_rw_last", 32'(buf_out), 189);
        chk("full_rw_empty", 32'(buf_empty), 1);
        @(negedge clk);
        #1;
        live = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
